// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch entry layout, the fetch FSM states and the NOP used for faults.
// No logic lives here apart from a small alignment helper.
package fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            misalign;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      FAULT_PUSH,
      FAULT_WAIT
   } fetch_state_e;

   // True when a byte address is not on a 32-bit instruction boundary.
   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, redirect and decode handshake signals.
// master = fetch unit, slave = surrounding pipeline / instruction memory.
// The instruction memory answers imem_addr_o combinationally on imem_instr_i.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic [XLEN-1:0] imem_addr_o;
   logic [XLEN-1:0] imem_instr_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [XLEN-1:0] out_pc_o;
   logic [XLEN-1:0] out_instr_o;
   logic            out_misalign_o;

   modport master (
      output imem_addr_o, out_valid_o, out_pc_o, out_instr_o, out_misalign_o,
      input  imem_instr_i, redirect_i, redirect_pc_i, out_ready_i
   );

   modport slave (
      input  imem_addr_o, out_valid_o, out_pc_o, out_instr_o, out_misalign_o,
      output imem_instr_i, redirect_i, redirect_pc_i, out_ready_i
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetch entries; head is read straight from storage.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: push is taken when not full or when popping the same cycle; flush wins over both.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fetch_fifo: FIFO_DEPTH must be a power of two and at least 2");
   end

   fetch_entry_t    mem [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !flush && !empty;
   assign do_push = push && !flush && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush rewinds everything to zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Entry storage; cleared at reset so the head outputs read zero until first push.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register + FSM feeding a FIFO of {pc, instr, misalign} to decode.
// Latency: one cycle push-to-out; 1 instr/cycle steady state; redirect flushes, new PC out 2 cycles later.
// Backpressure: fetch stalls (PC held) while the FIFO is full and decode is not popping. Optional macro: FETCH_PERF_CNT_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [63:0]   perf_fetched_o,
   output logic [63:0]   perf_stall_o,
   output logic [31:0]   perf_flush_o
`endif
);

   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("fetch_unit: RESET_PC must be 4-byte aligned");
   end

   fetch_state_e    state;
   logic [XLEN-1:0] pc_q;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;
   logic            full;
   logic            empty;
   logic            pop;
   logic            push_ok;
   logic            fetch_push;
   logic            fault_push;

   assign pop        = !empty && bus.out_ready_i;
   assign push_ok    = !full || pop;
   // A redirect cancels whatever this cycle would have pushed.
   assign fetch_push = (state == FETCH)      && push_ok && !bus.redirect_i;
   assign fault_push = (state == FAULT_PUSH) && push_ok && !bus.redirect_i;

   always_comb begin
      push_entry.pc       = pc_q;
      push_entry.instr    = fault_push ? NOP_INSTR : bus.imem_instr_i;
      push_entry.misalign = fault_push;
   end

   fetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push       (fetch_push || fault_push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (bus.redirect_i),
      .full       (full),
      .empty      (empty),
      .head       (head)
   );

   assign bus.imem_addr_o    = pc_q;
   assign bus.out_valid_o    = !empty;
   assign bus.out_pc_o       = head.pc;
   assign bus.out_instr_o    = head.instr;
   assign bus.out_misalign_o = head.misalign;

   // Fetch FSM and PC: redirect overrides everything, including the BOOT wait.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= BOOT;
         pc_q  <= RESET_PC;
      end else if (bus.redirect_i) begin
         pc_q  <= bus.redirect_pc_i;
         state <= is_misaligned(bus.redirect_pc_i) ? FAULT_PUSH : FETCH;
      end else begin
         case (state)
            BOOT:       state <= FETCH;
            FETCH:      if (push_ok) pc_q <= pc_q + 32'd4;
            FAULT_PUSH: if (push_ok) state <= FAULT_WAIT;
            FAULT_WAIT: ;
            default:    state <= BOOT;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic fetch_stall;
   assign fetch_stall = (state == FETCH) && !push_ok;

   // Saturating event counters; only reset clears them, flushes do not.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_fetched_o <= '0;
         perf_stall_o   <= '0;
         perf_flush_o   <= '0;
      end else begin
         if (fetch_push && (perf_fetched_o != '1))   perf_fetched_o <= perf_fetched_o + 64'd1;
         if (fetch_stall && (perf_stall_o != '1))    perf_stall_o   <= perf_stall_o + 64'd1;
         if (bus.redirect_i && (perf_flush_o != '1)) perf_flush_o   <= perf_flush_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with a queue-based reference model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fetch_unit_if bus();
   fetch_unit_if bus2();

   // Instruction memory: word i holds 0x1000_0000 + i.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'h1000_0000 + (addr >> 2);
   endfunction

   assign bus.imem_instr_i  = mem_word(bus.imem_addr_o);
   assign bus2.imem_instr_i = mem_word(bus2.imem_addr_o);

`ifdef FETCH_PERF_CNT_EN
   logic [63:0] pf_fetched, pf_stall, p2_fetched, p2_stall;
   logic [31:0] pf_flush, p2_flush;
`endif

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o (pf_fetched),
      .perf_stall_o   (pf_stall),
      .perf_flush_o   (pf_flush)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_wrap (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus2)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o (p2_fetched),
      .perf_stall_o   (p2_stall),
      .perf_flush_o   (p2_flush)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Abstract view: a bounded queue of expected entries plus "what is fetch doing".
   fetch_entry_t mq[$];
   logic [31:0]  m_pc      = 32'h0;
   bit           m_boot    = 1'b1;
   bit           m_fault   = 1'b0;   // a misaligned target still has to be reported
   bit           m_halt    = 1'b0;   // fault reported, waiting for a redirect
   longint       m_fetched = 0;
   longint       m_stall   = 0;
   longint       m_flush   = 0;

   task automatic model_reset();
      mq.delete();
      m_pc = 32'h0; m_boot = 1'b1; m_fault = 1'b0; m_halt = 1'b0;
      m_fetched = 0; m_stall = 0; m_flush = 0;
   endtask

   // Model step at each rising edge; the monitor has already removed a popped entry,
   // so "room in the queue" is exactly the push-allowed rule.
   initial forever begin
      @(posedge clk);
      if (!rst) begin
         fetch_entry_t e;
         bit room;
         room = (mq.size() < DEPTH);
         if (!m_boot && !m_fault && !m_halt && !room) m_stall++;
         if (bus.redirect_i) begin
            mq.delete();
            m_pc    = bus.redirect_pc_i;
            m_fault = (bus.redirect_pc_i[1:0] != 2'b00);
            m_halt  = 1'b0;
            m_boot  = 1'b0;
            m_flush++;
         end else if (m_boot) begin
            m_boot = 1'b0;
         end else if (m_fault) begin
            if (room) begin
               e.pc = m_pc; e.instr = NOP_INSTR; e.misalign = 1'b1;
               mq.push_back(e);
               m_fault = 1'b0;
               m_halt  = 1'b1;
            end
         end else if (!m_halt && room) begin
            e.pc = m_pc; e.instr = mem_word(m_pc); e.misalign = 1'b0;
            mq.push_back(e);
            m_pc = m_pc + 32'd4;
            m_fetched++;
         end
      end
   end

   // Monitor: mid-cycle, compare address/valid and score every handshake.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("imem_addr", bus.imem_addr_o, m_pc);
         chk("out_valid", bus.out_valid_o, mq.size() != 0);
         if (bus.out_valid_o && bus.out_ready_i && mq.size() != 0) begin
            fetch_entry_t e;
            e = mq.pop_front();
            chk("out_pc", bus.out_pc_o, e.pc);
            chk("out_instr", bus.out_instr_o, e.instr);
            chk("out_misalign", bus.out_misalign_o, e.misalign);
         end
      end
   end

   // Wrap-around DUT: first three PCs after the initial reset release.
   initial begin
      logic [31:0] exp_pc [3];
      int k;
      exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
      k = 0;
      bus2.out_ready_i = 1'b1; bus2.redirect_i = 1'b0; bus2.redirect_pc_i = '0;
      @(negedge rst);
      for (int c = 0; c < 20 && k < 3; c++) begin
         @(negedge clk);
         if (bus2.out_valid_o) begin
            chk("wrap_pc", bus2.out_pc_o, exp_pc[k]);
            k++;
         end
      end
      if (k < 3) chk("wrap_timeout", k, 3);
   end

   task automatic chk_perf();
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", pf_fetched, m_fetched);
      chk("perf_stall", pf_stall, m_stall);
      chk("perf_flush", pf_flush, m_flush);
`endif
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      chk_perf();
      bus.redirect_i = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_valid", bus.out_valid_o, 0);
      chk("rst_pc", bus.out_pc_o, 0);
      chk("rst_instr", bus.out_instr_o, 0);
      chk("rst_misalign", bus.out_misalign_o, 0);
      chk("rst_addr", bus.imem_addr_o, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      bus.out_ready_i = 1'b1; bus.redirect_i = 1'b0; bus.redirect_pc_i = '0;

      // Reset release with decode always ready.
      apply_reset();
      cycle(); chk("boot_gap_valid", bus.out_valid_o, 0);
      cycle();
      chk("first_valid", bus.out_valid_o, 1);
      chk("first_pc", bus.out_pc_o, 32'h0);
      chk("first_instr", bus.out_instr_o, 32'h1000_0000);
      repeat (8) cycle();

      // Backpressure straight out of reset.
      bus.out_ready_i = 1'b0;
      apply_reset();
      repeat (5) cycle();
      chk("bp_addr_hold", bus.imem_addr_o, 32'h8);
      chk("bp_head_pc", bus.out_pc_o, 32'h0);
      bus.out_ready_i = 1'b1;
      repeat (6) cycle();

      // Redirect while full and popping.
      bus.out_ready_i = 1'b0;
      repeat (3) cycle();
      bus.out_ready_i = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0100;
      cycle(); bus.redirect_i = 1'b0;
      chk("flush_valid", bus.out_valid_o, 0);
      cycle();
      chk("redir_valid", bus.out_valid_o, 1);
      chk("redir_pc", bus.out_pc_o, 32'h0000_0100);
      repeat (5) cycle();

      // Misaligned redirect: a single fault entry, then silence.
      bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0102;
      cycle(); bus.redirect_i = 1'b0;
      cycle();
      chk("fault_valid", bus.out_valid_o, 1);
      chk("fault_pc", bus.out_pc_o, 32'h0000_0102);
      chk("fault_instr", bus.out_instr_o, 32'h0000_0013);
      chk("fault_misalign", bus.out_misalign_o, 1);
      for (int c = 0; c < 6; c++) begin
         cycle(); bus.out_ready_i = ($urandom_range(1) != 0);
      end
      bus.out_ready_i = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0200;
      cycle(); bus.redirect_i = 1'b0;
      repeat (6) cycle();

      // Random traffic, redirects and occasional mid-run resets.
      for (int c = 0; c < 3000; c++) begin
         cycle();
         bus.out_ready_i = ($urandom_range(3) != 0);
         if ($urandom_range(31) == 0) begin
            bus.redirect_i = 1'b1;
            case ($urandom_range(3))
               0:       bus.redirect_pc_i = $urandom & 32'hFFFF_FFFC;
               1:       bus.redirect_pc_i = 32'hFFFF_FFF0 + ($urandom_range(3) << 2);
               2:       bus.redirect_pc_i = $urandom;
               default: bus.redirect_pc_i = 32'h0000_0400 | $urandom_range(3);
            endcase
         end else begin
            bus.redirect_i = 1'b0;
         end
         if ($urandom_range(999) == 0) apply_reset();
      end
      bus.redirect_i = 1'b0;
      repeat (3) cycle();
      chk_perf();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
